// File: rtl/vga_plot_sink.sv
// vga_plot_sink: pixel-plot receiver with an internal 160x120x15 framebuffer,
// scanned out as 640x480@60 Hz VGA (4x4 blocks per stored pixel).
// Ports:
//   clock, reset              50 MHz board clock, async active-high reset
//   plot, plot_x/y/color      write strobe and pixel payload {R,G,B} 5:5:5
//   clear                     request to fill the framebuffer with BACKGROUND
//   ready                     plot writes accepted (IDLE)
//   vga_clk                   25 MHz pixel clock
//   vga_hs/vs/blank_n/sync_n  VGA timing controls (hs/vs active low)
//   vga_r/g/b                 10-bit DAC channels
module vga_plot_sink #(
  parameter logic [14:0] BACKGROUND = 15'h0000,
  parameter int unsigned FB_W       = 160,
  parameter int unsigned FB_H       = 120
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        plot,
  input  logic [7:0]  plot_x,
  input  logic [6:0]  plot_y,
  input  logic [14:0] plot_color,
  input  logic        clear,
  output logic        ready,
  output logic        vga_clk,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic [9:0]  vga_r,
  output logic [9:0]  vga_g,
  output logic [9:0]  vga_b
);

  localparam int unsigned AW       = 15;
  localparam int unsigned CW       = 10;
  localparam int unsigned FB_SIZE  = FB_W * FB_H;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned H_VIS    = 640;
  localparam int unsigned H_SYNC_S = 656;
  localparam int unsigned H_SYNC_E = 752;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned V_VIS    = 480;
  localparam int unsigned V_SYNC_S = 490;
  localparam int unsigned V_SYNC_E = 492;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FB_SIZE - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic            ready_q, ready_d;
  logic            pix_en_q, pix_en_d;
  logic [CW-1:0]   h_q, h_d;
  logic [CW-1:0]   v_q, v_d;
  logic            hs1_q, hs1_d, vs1_q, vs1_d, vis1_q, vis1_d;
  logic            hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic [9:0]      r_q, r_d, g_q, g_d, b_q, b_d;
  logic [14:0]     rd_q;

  logic            we_c;
  logic [AW-1:0]   waddr_c;
  logic [14:0]     wdata_c;
  logic            plot_in_range_c;
  logic [AW-1:0]   plot_addr_c;
  logic [AW-1:0]   raddr_c;
  logic            vis_c;
  logic [7:0]      vrow_c, hcol_c;

  logic [14:0] mem [FB_SIZE];

  // Plot address y*160+x as (y<<7)+(y<<5)+x
  assign plot_in_range_c = (32'(plot_x) < FB_W) && (32'(plot_y) < FB_H);
  assign plot_addr_c     = AW'({plot_y, 7'b0}) + AW'({plot_y, 5'b0}) + AW'(plot_x);

  // Scan address (v>>2)*160 + (h>>2); only used while visible
  assign vrow_c  = v_q[CW-1:2];
  assign hcol_c  = h_q[CW-1:2];
  assign raddr_c = AW'({vrow_c, 7'b0}) + AW'({vrow_c, 5'b0}) + AW'(hcol_c);
  assign vis_c   = (h_q < CW'(H_VIS)) && (v_q < CW'(V_VIS));

  // Write-port arbitration and clear sweep
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    we_c       = 1'b0;
    waddr_c    = '0;
    wdata_c    = BACKGROUND;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end else if (plot && plot_in_range_c) begin
          we_c    = 1'b1;
          waddr_c = plot_addr_c;
          wdata_c = plot_color;
        end
      end
      S_CLEAR: begin
        we_c    = 1'b1;
        waddr_c = clr_addr_q;
        wdata_c = BACKGROUND;
        if (clr_addr_q == LAST_ADDR) state_d = S_IDLE;
        else                         clr_addr_d = clr_addr_q + AW'(1);
      end
      default: state_d = S_CLEAR;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // Timing counters, advancing on every second clock
  always_comb begin
    pix_en_d = ~pix_en_q;
    h_d      = h_q;
    v_d      = v_q;
    if (pix_en_q) begin
      if (h_q == CW'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  // Stage 1 tracks the memory read; stage 2 drives the pins together
  always_comb begin
    hs1_d     = !((h_q >= CW'(H_SYNC_S)) && (h_q < CW'(H_SYNC_E)));
    vs1_d     = !((v_q >= CW'(V_SYNC_S)) && (v_q < CW'(V_SYNC_E)));
    vis1_d    = vis_c;
    hs_d      = hs1_q;
    vs_d      = vs1_q;
    blank_n_d = vis1_q;
    r_d       = '0;
    g_d       = '0;
    b_d       = '0;
    if (vis1_q) begin
      r_d = {rd_q[14:10], rd_q[14:10]};
      g_d = {rd_q[9:5],   rd_q[9:5]};
      b_d = {rd_q[4:0],   rd_q[4:0]};
    end
  end

  // Framebuffer: one write port, one scan-out read port, no reset
  always_ff @(posedge clock) begin
    if (we_c)  mem[waddr_c] <= wdata_c;
    if (vis_c) rd_q <= mem[raddr_c];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
      pix_en_q   <= 1'b0;
      h_q        <= '0;
      v_q        <= '0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      vis1_q     <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_n_q  <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ready_q    <= ready_d;
      pix_en_q   <= pix_en_d;
      h_q        <= h_d;
      v_q        <= v_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      vis1_q     <= vis1_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      blank_n_q  <= blank_n_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
    end
  end

  assign ready       = ready_q;
  assign vga_clk     = pix_en_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b1;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Bench for vga_plot_sink: scan-out is predicted from the elapsed clock count
// and a framebuffer model; plots come from a vector table plus random stimulus.
module tb_vga_plot_sink;

  localparam logic [14:0] BG   = 15'h0421;
  localparam int          NPIX = 19200;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        plot = 1'b0, clear = 1'b0;
  logic [7:0]  plot_x = '0;
  logic [6:0]  plot_y = '0;
  logic [14:0] plot_color = '0;
  logic        ready, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [9:0]  vga_r, vga_g, vga_b;

  vga_plot_sink #(.BACKGROUND(BG), .FB_W(160), .FB_H(120)) dut (
    .clock(clock), .reset(reset), .plot(plot), .plot_x(plot_x), .plot_y(plot_y),
    .plot_color(plot_color), .clear(clear), .ready(ready), .vga_clk(vga_clk),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #10 clock = ~clock;

  int          tests = 0, fails = 0;
  int          ncyc = 0;
  logic        colour_chk = 1'b0;
  logic        model_idle = 1'b0;
  logic [14:0] fb_model [NPIX];
  int          line_cycles = 0, line_err = 0;
  string       line_msg = "";

  typedef struct {
    logic        p;
    logic        cl;
    int          x;
    int          y;
    logic [14:0] c;
    logic        exp_ready;
  } vec_t;
  vec_t vt[8];

  typedef struct {
    int          h;
    int          v;
    logic [14:0] c;
  } pix_t;
  pix_t pt[7];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected pin state after n clocks: outputs show the pixel whose counter
  // state was current two clocks earlier; the pixel index is clocks/2.
  task automatic check_cycle(input int n);
    int p, h, v;
    logic e_hs, e_vs, e_vis, bad;
    logic [14:0] c;
    logic [9:0] er, eg, eb;
    e_hs = 1'b1; e_vs = 1'b1; e_vis = 1'b0; c = '0; h = -1; v = -1;
    if (n >= 2) begin
      p = (n - 2) / 2;
      h = p % 800;
      v = (p / 800) % 525;
      e_hs  = !(h >= 656 && h < 752);
      e_vs  = !(v >= 490 && v < 492);
      e_vis = (h < 640) && (v < 480);
      if (e_vis) c = fb_model[(v / 4) * 160 + h / 4];
    end
    er = 10'(c[14:10] * 33);
    eg = 10'(c[9:5] * 33);
    eb = 10'(c[4:0] * 33);
    bad = (vga_clk !== 1'(n % 2)) || (vga_hs !== e_hs) || (vga_vs !== e_vs) ||
          (vga_blank_n !== e_vis) || (vga_sync_n !== 1'b1);
    if (!e_vis) bad = bad || (vga_r !== 10'd0) || (vga_g !== 10'd0) || (vga_b !== 10'd0);
    else if (colour_chk) bad = bad || (vga_r !== er) || (vga_g !== eg) || (vga_b !== eb);
    line_cycles++;
    if (bad) begin
      if (line_err == 0)
        line_msg = $sformatf("n=%0d h=%0d got clk=%b hs=%b vs=%b bn=%b rgb=%h/%h/%h want clk=%0d hs=%b vs=%b bn=%b rgb=%h/%h/%h",
                             n, h, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b,
                             n % 2, e_hs, e_vs, e_vis, er, eg, eb);
      line_err++;
    end
    if (n >= 3 && h == 799 && (n % 2) == 1) begin
      chk($sformatf("scan line %0d bad cycles [%s]", v, line_msg), line_err, 0);
      line_cycles = 0; line_err = 0; line_msg = "";
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      if (line_cycles > 0) chk($sformatf("partial line before reset [%s]", line_msg), line_err, 0);
      line_cycles = 0; line_err = 0; line_msg = ""; ncyc = 0;
    end else begin
      ncyc++;
      #1;
      check_cycle(ncyc);
    end
  end

  task automatic wait_n(input int t);
    int guard;
    guard = 0;
    while (ncyc < t && guard < 120000) begin
      @(posedge clock); #1;
      guard++;
    end
    chk($sformatf("reach cycle %0d", t), ncyc, t);
  endtask

  // Drive one cycle of plot/clear inputs and apply the plotting rules to the model
  task automatic drive(input logic p, input logic cl, input int x, input int y, input logic [14:0] c);
    plot = p; clear = cl; plot_x = 8'(x); plot_y = 7'(y); plot_color = c;
    if (model_idle) begin
      if (cl) model_idle = 1'b0;
      else if (p && x < 160 && y < 120) fb_model[y * 160 + x] = c;
    end
  endtask

  task automatic pix_check(input int h, input int v, input logic [14:0] c);
    wait_n(2 * (v * 800 + h) + 2);
    chk($sformatf("pix(%0d,%0d) r", h, v), int'(vga_r), int'(c[14:10]) * 33);
    chk($sformatf("pix(%0d,%0d) g", h, v), int'(vga_g), int'(c[9:5]) * 33);
    chk($sformatf("pix(%0d,%0d) b", h, v), int'(vga_b), int'(c[4:0]) * 33);
    chk($sformatf("pix(%0d,%0d) blank_n", h, v), int'(vga_blank_n), 1);
  endtask

  initial begin
    int k, lo, per, x;
    vt[0] = '{1'b1, 1'b0, 10,  5,   15'h7C00, 1'b1};
    vt[1] = '{1'b1, 1'b0, 200, 5,   15'h7FFF, 1'b1};
    vt[2] = '{1'b1, 1'b0, 3,   127, 15'h7FFF, 1'b1};
    vt[3] = '{1'b1, 1'b0, 0,   9,   15'h7FFF, 1'b1};
    vt[4] = '{1'b1, 1'b0, 160, 0,   15'h7FFF, 1'b1};
    vt[5] = '{1'b1, 1'b0, 0,   120, 15'h7FFF, 1'b1};
    vt[6] = '{1'b1, 1'b0, 159, 5,   15'h03E0, 1'b1};
    vt[7] = '{1'b0, 1'b0, 20,  5,   15'h7FFF, 1'b1};
    pt[0] = '{40,  19, BG};
    pt[1] = '{39,  20, BG};
    pt[2] = '{40,  20, 15'h7C00};
    pt[3] = '{43,  20, 15'h7C00};
    pt[4] = '{44,  20, BG};
    pt[5] = '{636, 20, 15'h03E0};
    pt[6] = '{41,  23, 15'h7C00};

    // Reset, then abort the power-on clear midway
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    repeat (9000) @(posedge clock);
    #1;
    chk("ready low during clear", int'(ready), 0);
    #3 reset = 1'b1;
    #1;
    chk("reset ready", int'(ready), 0);
    chk("reset vga_clk", int'(vga_clk), 0);
    chk("reset hs", int'(vga_hs), 1);
    chk("reset vs", int'(vga_vs), 1);
    chk("reset blank_n", int'(vga_blank_n), 0);
    chk("reset rgb", int'({vga_r, vga_g, vga_b}), 0);
    chk("reset sync_n", int'(vga_sync_n), 1);
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;

    // Full clear after reset release
    k = 0;
    while (k < 20000) begin
      @(posedge clock); #1;
      k++;
      if (ready) break;
    end
    chk("clocks until ready after reset", k, 19200);
    foreach (fb_model[i]) fb_model[i] = BG;
    model_idle = 1'b1;
    colour_chk = 1'b1;

    // Table-driven plots
    foreach (vt[i]) begin
      drive(vt[i].p, vt[i].cl, vt[i].x, vt[i].y, vt[i].c);
      @(posedge clock); #1;
      chk($sformatf("vec %0d ready", i), int'(ready), int'(vt[i].exp_ready));
    end
    // Random plots along row 5, keeping the hand-checked pixels untouched
    for (int i = 0; i < 24; i++) begin
      x = int'($urandom_range(0, 179));
      if (x >= 9 && x <= 11) x = 12;
      if (x == 159) x = 170;
      drive(1'b1, 1'b0, x, 5, 15'($urandom));
      @(posedge clock); #1;
      chk($sformatf("rand %0d ready", i), int'(ready), 1);
    end
    drive(1'b0, 1'b0, 0, 0, 15'h0);

    // Horizontal timing
    k = 0;
    while (vga_hs !== 1'b0 && k < 2000) begin @(posedge clock); #1; k++; end
    chk("hs fall seen", int'(k < 2000), 1);
    chk("hs fall pixel", ((ncyc - 2) / 2) % 800, 656);
    chk("hs fall on pixel start", (ncyc - 2) % 2, 0);
    lo = 0;
    while (vga_hs === 1'b0 && lo < 400) begin @(posedge clock); #1; lo++; end
    chk("hs low clocks", lo, 192);
    per = lo;
    while (vga_hs !== 1'b0 && per < 2000) begin @(posedge clock); #1; per++; end
    chk("line period clocks", per, 1600);

    // Plotted block and its neighbours
    foreach (pt[i]) pix_check(pt[i].h, pt[i].v, pt[i].c);

    // Clear and plot together: clear wins; later clear/plot requests ignored
    wait_n(37000);
    colour_chk = 1'b0;
    drive(1'b1, 1'b1, 0, 9, 15'h001F);
    @(posedge clock); #1;
    chk("ready falls on clear", int'(ready), 0);
    drive(1'b0, 1'b0, 0, 0, 15'h0);
    k = 0;
    while (k < 20000) begin
      @(posedge clock); #1;
      k++;
      if (ready) break;
      if (k == 5000) drive(1'b1, 1'b1, 1, 9, 15'h7C00);
      else           drive(1'b0, 1'b0, 0, 0, 15'h0);
    end
    drive(1'b0, 1'b0, 0, 0, 15'h0);
    chk("clocks ready low for clear", k, 19200);
    foreach (fb_model[i]) fb_model[i] = BG;
    model_idle = 1'b1;
    colour_chk = 1'b1;

    pix_check(0, 36, BG);
    pix_check(3, 36, BG);
    pix_check(4, 36, BG);
    wait_n(2 * (36 * 800 + 799) + 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
